// File: rtl/parking_space_tracker.sv
// Entry-side parking controller: gate FSM with timeout, sensor edge detection,
// space-class allocation and saturating per-class free-space counters.
module parking_space_tracker #(
    parameter int CAP_SPEC_0   = 2,
    parameter int CAP_NORM_0   = 3,
    parameter int CAP_FLR_1    = 5,
    parameter int GATE_TIMEOUT = 50
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       car_arrive,
    input  logic       req_special,
    input  logic       req_floor,
    input  logic       car_passed,
    input  logic       exit_spec_0,
    input  logic       exit_norm_0,
    input  logic       exit_flr_1,
    output logic       gate_open,
    output logic       denied,
    output logic       full,
    output logic [2:0] remain_flr_spec_0,
    output logic [2:0] remain_flr_norm_0,
    output logic [2:0] remain_flr_1
);

    localparam int TW = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_TIMEOUT - 1);
    localparam logic [2:0] CAP_S = CAP_SPEC_0[2:0];
    localparam logic [2:0] CAP_N = CAP_NORM_0[2:0];
    localparam logic [2:0] CAP_F = CAP_FLR_1[2:0];

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_SPEC = 2'd1;
    localparam logic [1:0] CLS_NORM = 2'd2;
    localparam logic [1:0] CLS_FLR1 = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ALLOC,
        OPEN,
        CLOSE,
        WAIT_LEAVE
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_prev_arrive, r_prev_passed;
    logic          r_prev_xs, r_prev_xn, r_prev_xf;
    logic          r_req_special, r_req_floor;
    logic [1:0]    r_alloc;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_cnt_s, r_cnt_n, r_cnt_f;
    logic          r_gate_open, r_denied;

    logic       w_arrive_edge, w_passed_edge;
    logic       w_xs_edge, w_xn_edge, w_xf_edge;
    logic [1:0] w_grant_cls;
    logic       w_timeout;
    logic       w_dec_s, w_dec_n, w_dec_f;
    logic       w_rest_s, w_rest_n, w_rest_f;

    // Exit at capacity is a spurious sensor pulse and is dropped before summing.
    function automatic logic [2:0] cnt_next(input logic [2:0] cnt, input logic [2:0] cap,
                                            input logic inc, input logic rest, input logic dec);
        logic [3:0] sum;
        sum = {1'b0, cnt} + {3'b000, inc && (cnt < cap)} + {3'b000, rest} - {3'b000, dec};
        if (sum > {1'b0, cap}) sum = {1'b0, cap};
        return sum[2:0];
    endfunction

    assign w_arrive_edge = car_arrive  & ~r_prev_arrive;
    assign w_passed_edge = car_passed  & ~r_prev_passed;
    assign w_xs_edge     = exit_spec_0 & ~r_prev_xs;
    assign w_xn_edge     = exit_norm_0 & ~r_prev_xn;
    assign w_xf_edge     = exit_flr_1  & ~r_prev_xf;

    always_comb begin
        w_grant_cls = CLS_NONE;
        if (r_req_special) begin
            if (r_cnt_s != 3'd0)      w_grant_cls = CLS_SPEC;
            else if (r_cnt_n != 3'd0) w_grant_cls = CLS_NORM;
            else if (r_cnt_f != 3'd0) w_grant_cls = CLS_FLR1;
        end else if (!r_req_floor) begin
            if (r_cnt_n != 3'd0)      w_grant_cls = CLS_NORM;
            else if (r_cnt_f != 3'd0) w_grant_cls = CLS_FLR1;
        end else begin
            if (r_cnt_f != 3'd0)      w_grant_cls = CLS_FLR1;
            else if (r_cnt_n != 3'd0) w_grant_cls = CLS_NORM;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE:       if (w_arrive_edge) w_next_state = ALLOC;
            ALLOC:      w_next_state = (w_grant_cls != CLS_NONE) ? OPEN : WAIT_LEAVE;
            OPEN: begin
                if (w_passed_edge) begin
                    w_next_state = CLOSE;
                end else if (r_timer == TIMER_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = CLOSE;
                end
            end
            CLOSE:      w_next_state = WAIT_LEAVE;
            WAIT_LEAVE: if (!car_arrive) w_next_state = IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    assign w_dec_s  = (r_state == ALLOC) && (w_grant_cls == CLS_SPEC);
    assign w_dec_n  = (r_state == ALLOC) && (w_grant_cls == CLS_NORM);
    assign w_dec_f  = (r_state == ALLOC) && (w_grant_cls == CLS_FLR1);
    assign w_rest_s = w_timeout && (r_alloc == CLS_SPEC);
    assign w_rest_n = w_timeout && (r_alloc == CLS_NORM);
    assign w_rest_f = w_timeout && (r_alloc == CLS_FLR1);

    // Sensor history resets high so a sensor already active through reset gives no edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prev_arrive <= 1'b1;
            r_prev_passed <= 1'b1;
            r_prev_xs     <= 1'b1;
            r_prev_xn     <= 1'b1;
            r_prev_xf     <= 1'b1;
            r_req_special <= 1'b0;
            r_req_floor   <= 1'b0;
            r_alloc       <= CLS_NONE;
            r_timer       <= '0;
            r_cnt_s       <= CAP_S;
            r_cnt_n       <= CAP_N;
            r_cnt_f       <= CAP_F;
            r_gate_open   <= 1'b0;
            r_denied      <= 1'b0;
        end else begin
            r_prev_arrive <= car_arrive;
            r_prev_passed <= car_passed;
            r_prev_xs     <= exit_spec_0;
            r_prev_xn     <= exit_norm_0;
            r_prev_xf     <= exit_flr_1;
            if (r_state == IDLE && w_arrive_edge) begin
                r_req_special <= req_special;
                r_req_floor   <= req_floor;
            end
            if (r_state == ALLOC) begin
                r_alloc <= w_grant_cls;
                r_timer <= '0;
            end else if (r_state == OPEN) begin
                r_timer <= r_timer + TW'(1);
            end
            r_cnt_s     <= cnt_next(r_cnt_s, CAP_S, w_xs_edge, w_rest_s, w_dec_s);
            r_cnt_n     <= cnt_next(r_cnt_n, CAP_N, w_xn_edge, w_rest_n, w_dec_n);
            r_cnt_f     <= cnt_next(r_cnt_f, CAP_F, w_xf_edge, w_rest_f, w_dec_f);
            r_gate_open <= (w_next_state == OPEN);
            r_denied    <= (r_state == ALLOC) && (w_grant_cls == CLS_NONE);
        end
    end

    assign gate_open         = r_gate_open;
    assign denied            = r_denied;
    assign full              = (r_cnt_s == 3'd0) && (r_cnt_n == 3'd0) && (r_cnt_f == 3'd0);
    assign remain_flr_spec_0 = r_cnt_s;
    assign remain_flr_norm_0 = r_cnt_n;
    assign remain_flr_1      = r_cnt_f;

endmodule

// File: doc/parking_space_tracker.md
Name: parking_space_tracker

Overview:
- Front end of the parking controller: admits cars at the entry gate, allocates a space class, tracks exits and maintains the remaining-space counters.
- Its counters drive the per-floor remaining-space inputs of the seven-segment display driver (special floor 0, normal floor 0, floor 1).
- Contains a gate FSM with timeout, rising-edge detection on all sensors, and saturating up/down counters.

Parameters:
- CAP_SPEC_0, 2, special (permit) spaces on floor 0.
- CAP_NORM_0, 3, normal spaces on floor 0.
- CAP_FLR_1, 5, spaces on floor 1.
- GATE_TIMEOUT, 50, cycles the gate stays open waiting for car_passed.
- Constraints: all capacities 0..7 (3-bit outputs); CAP_SPEC_0 + CAP_NORM_0 <= 5; CAP_FLR_1 <= 5.

Ports:
- CLK  in  1  system clock, all logic on its rising edge.
- RST  in  1  synchronous reset, active-high.
- car_arrive  in  1  entry presence sensor (level).
- req_special  in  1  car holds special permit; sampled on the car_arrive edge.
- req_floor  in  1  preferred floor (0/1); sampled on the car_arrive edge.
- car_passed  in  1  sensor behind the entry gate (level).
- exit_spec_0, exit_norm_0, exit_flr_1  in  1 each  exit sensors per space class (level).
- gate_open  out  1  entry barrier command.
- denied  out  1  one-cycle pulse: no space available for this car.
- full  out  1  high when all three counters are 0.
- remain_flr_spec_0, remain_flr_norm_0, remain_flr_1  out  3 each  free spaces per class.

Behaviour:
- Clock and reset: one clock, CLK; RST is synchronous, active-high.
- Reset values:
  - counters = CAP_SPEC_0 / CAP_NORM_0 / CAP_FLR_1
  - gate_open = 0, denied = 0, full = 0 (or 1 if every capacity is 0)
  - state = IDLE, timer = 0, stored allocation cleared
- Edge detection: every sensor input has a registered previous-value flop that resets to 1. An input held high through reset therefore produces no edge. An edge is cur=1 & prev=0.
- FSM states: IDLE, ALLOC, OPEN, CLOSE, WAIT_LEAVE.
- IDLE: on a car_arrive edge, latch req_special and req_floor, then go to ALLOC.
- ALLOC (exactly one cycle): pick the first class in the priority list below whose counter is > 0.
  - Special car: spec_0, then norm_0, then flr_1.
  - Normal car with req_floor=0: norm_0, then flr_1.
  - Normal car with req_floor=1: flr_1, then norm_0.
  - Normal cars never take special spaces.
  - If a class is granted: decrement that counter (reservation), set gate_open=1, clear the timer, go to OPEN.
  - If nothing is free: pulse denied=1 for one cycle, go to WAIT_LEAVE.
  - Latency: car_arrive edge sampled at edge k gives gate_open/denied high after edge k+1.
- OPEN: the timer increments each cycle.
  - car_passed edge: go to CLOSE; the reservation stands.
  - Timer reaches GATE_TIMEOUT with no car_passed edge: increment the reserved counter back, go to CLOSE.
- CLOSE (one cycle): gate_open=0, then go to WAIT_LEAVE.
- WAIT_LEAVE: wait for car_arrive=0, then go to IDLE. This prevents one standing car being admitted twice.
- Exits are processed in every state except during reset. A rising edge on exit_x increments counter x, saturating at its capacity. An exit edge at capacity is ignored (spurious sensor).
- Simultaneous events on the same counter in the same cycle:
  - Exit increment with allocation decrement: net unchanged.
  - Exit increment with timeout restore: +1, saturating at capacity.
- ALLOC uses the counter values registered before the current cycle's exit edges.
- Counters are never decremented below 0 (grant requires > 0).
- full is combinational from the counter registers.
- RST asserted in any state: all state returns to reset values on the next edge, the gate closes immediately, and any reservation is discarded (counters restore to capacity).

Test Plan:
- Reset with car_arrive held 1 -> no admission. Counters 2/3/5, gate_open=0. Drop then raise car_arrive -> gate_open=1 two cycles later.
- Special car, then car_passed -> remain_flr_spec_0 2->1 and gate_open 1->0. A second car with car_arrive held high is not re-admitted until car_arrive drops.
- Three normal req_floor=0 cars each passing -> norm_0 3->0. A fourth normal req_floor=0 car -> flr_1 5->4.
- Fill all ten spaces -> full=1. An 11th car -> denied high exactly one cycle, gate_open stays 0, counters unchanged.
- Car granted flr_1 (5->4), no car_passed for 50 cycles -> gate_open=0 and flr_1 back to 5.
- flr_1=4, exit_flr_1 edge in the same cycle as an ALLOC to flr_1 -> flr_1 stays 4.
- exit_spec_0 edge with spec_0=2 -> stays 2.
